// File: rtl/nms_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nms_pkg
//  Description : Shared encodings for the non-maximal suppression / double
//                threshold stage: class codes, gradient direction codes and
//                the row sequencing state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package nms_pkg;

    // Output classification
    localparam logic [1:0] CLS_NONE   = 2'b00;
    localparam logic [1:0] CLS_WEAK   = 2'b01;
    localparam logic [1:0] CLS_STRONG = 2'b10;

    // Quantised gradient direction carried in pixel bits [1:0]
    localparam logic [1:0] DIR_V    = 2'd0;  // compare top / bottom
    localparam logic [1:0] DIR_D45  = 2'd1;  // compare top-right / bottom-left
    localparam logic [1:0] DIR_H    = 2'd2;  // compare left / right
    localparam logic [1:0] DIR_D135 = 2'd3;  // compare top-left / bottom-right

    // Row sequencing
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } nms_state_t;

endpackage
`default_nettype wire

// File: rtl/nms_window.sv
`default_nettype none
// ============================================================================
//  Module      : nms_window
//  Description : 3x3 pixel window built from three column registers. A new
//                column enters on the right and the oldest drops off the left.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                shift           - advance the window by one column
//                clear           - with shift: zero the two older columns and
//                                  load the incoming column (start of frame)
//                zero_fill       - with shift: shift in an all-zero column
//                din1/din2/din3  - top / middle / bottom pixel of new column
//                win[row][col]   - window, row 0 = top, col 0 = oldest (left)
//  Revision    : 1.0 - initial release
// ============================================================================
module nms_window
    import nms_pkg::*;
#(
    parameter int PIX_W = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shift,
    input  logic                         clear,
    input  logic                         zero_fill,
    input  logic [PIX_W-1:0]             din1,
    input  logic [PIX_W-1:0]             din2,
    input  logic [PIX_W-1:0]             din3,
    output logic [2:0][2:0][PIX_W-1:0]   win
);

    logic [2:0][PIX_W-1:0] w_din;

    assign w_din = {din3, din2, din1};

    generate
        for (genvar r = 0; r < 3; r++) begin : g_row
            logic [2:0][PIX_W-1:0] r_row;
            logic [PIX_W-1:0]      w_new;

            assign w_new = zero_fill ? '0 : w_din[r];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_row <= '0;
                end else if (shift) begin
                    r_row[0] <= clear ? '0 : r_row[1];
                    r_row[1] <= clear ? '0 : r_row[2];
                    r_row[2] <= w_new;
                end
            end

            assign win[r] = r_row;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/nms_hysteresis.sv
`default_nettype none
// ============================================================================
//  Module      : nms_hysteresis
//  Description : Non-maximal suppression and double-threshold classification
//                of Sobel magnitude/direction pixels, one column of three rows
//                per accepted beat, with an end-of-row flush step.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                valid_in / ready_out  - column beat handshake
//                sof                   - first beat of frame (latches thresholds)
//                din1/din2/din3        - top / middle / bottom {mag, dir}
//                th_high, th_low       - strong / weak thresholds
//                valid_out, dout, cls  - result for one centre pixel
//                eol_out               - result belongs to the last column
//  Revision    : 1.0 - initial release
// ============================================================================
module nms_hysteresis
    import nms_pkg::*;
#(
    parameter int IMG_W    = 250,
    parameter int MAG_W    = 8,
    parameter int CNT_W    = 11,
    parameter int OUT_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic               sof,
    input  logic [MAG_W+1:0]   din1,
    input  logic [MAG_W+1:0]   din2,
    input  logic [MAG_W+1:0]   din3,
    input  logic [MAG_W-1:0]   th_high,
    input  logic [MAG_W-1:0]   th_low,
    output logic               valid_out,
    output logic [MAG_W-1:0]   dout,
    output logic [1:0]         cls,
    output logic               eol_out
);

    localparam int               c_pix_w    = MAG_W + 2;
    localparam logic [CNT_W-1:0] c_last_col = CNT_W'(IMG_W - 1);

    nms_state_t                       r_state, w_state_nx;
    logic [CNT_W-1:0]                 r_cnt, w_cnt_nx, w_cnt_inc;
    logic                             r_issue, w_issue_nx;
    logic [CNT_W-1:0]                 r_issue_col, w_issue_col_nx;
    logic [MAG_W-1:0]                 r_th_high, r_th_low;
    logic                             w_accept, w_sof_acc, w_kill;
    logic                             w_shift, w_clear, w_zero_fill;
    logic [2:0][2:0][c_pix_w-1:0]     w_win;
    logic [2:0][2:0][MAG_W-1:0]       w_mag;
    logic [MAG_W-1:0]                 w_mag_c, w_nb_a, w_nb_b, w_dout;
    logic [1:0]                       w_dir_c, w_cls;
    logic                             w_border, w_survivor;
    logic                             w_unused_dir;

    // ------------------------------------------------------------------
    // Window
    // ------------------------------------------------------------------
    nms_window #(.PIX_W(c_pix_w)) u_window (
        .clk       (clk),
        .rst       (rst),
        .shift     (w_shift),
        .clear     (w_clear),
        .zero_fill (w_zero_fill),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .win       (w_win)
    );

    generate
        for (genvar r = 0; r < 3; r++) begin : g_mag_row
            for (genvar c = 0; c < 3; c++) begin : g_mag_col
                assign w_mag[r][c] = w_win[r][c][c_pix_w-1:2];
            end
        end
    endgenerate

    assign w_mag_c = w_mag[1][1];
    assign w_dir_c = w_win[1][1][1:0];

    // Only the centre pixel's direction steers the comparison.
    assign w_unused_dir = ^{w_win[0][0][1:0], w_win[0][1][1:0], w_win[0][2][1:0],
                            w_win[1][0][1:0], w_win[1][2][1:0],
                            w_win[2][0][1:0], w_win[2][1][1:0], w_win[2][2][1:0]};

    // ------------------------------------------------------------------
    // Row sequencing
    // ------------------------------------------------------------------
    assign ready_out = (r_state != ST_FLUSH);
    assign w_accept  = valid_in && ready_out;
    assign w_sof_acc = w_accept && sof;
    // A restart mid-row discards the centre issued by the previous beat.
    assign w_kill    = w_sof_acc && (r_state == ST_RUN);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_issue_nx     = 1'b0;
        w_issue_col_nx = r_cnt;
        w_shift        = 1'b0;
        w_clear        = 1'b0;
        w_zero_fill    = 1'b0;
        if (w_sof_acc) begin
            w_state_nx = ST_RUN;
            w_cnt_nx   = '0;
            w_shift    = 1'b1;
            w_clear    = 1'b1;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        w_shift    = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        w_shift    = 1'b1;
                        w_issue_nx = 1'b1;
                        w_cnt_nx   = w_cnt_inc;
                        if (w_cnt_inc == c_last_col) begin
                            w_state_nx = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    w_shift        = 1'b1;
                    w_zero_fill    = 1'b1;
                    w_issue_nx     = 1'b1;
                    w_issue_col_nx = c_last_col;
                    w_cnt_nx       = '0;
                    w_state_nx     = ST_FILL;
                end
                default: w_state_nx = ST_FILL;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Suppression and classification of the issued centre
    // ------------------------------------------------------------------
    always_comb begin
        case (w_dir_c)
            DIR_V:   begin w_nb_a = w_mag[0][1]; w_nb_b = w_mag[2][1]; end
            DIR_D45: begin w_nb_a = w_mag[0][2]; w_nb_b = w_mag[2][0]; end
            DIR_H:   begin w_nb_a = w_mag[1][0]; w_nb_b = w_mag[1][2]; end
            default: begin w_nb_a = w_mag[0][0]; w_nb_b = w_mag[2][2]; end
        endcase
    end

    assign w_border   = (r_issue_col == '0) || (r_issue_col == c_last_col);
    assign w_survivor = !w_border && (w_mag_c >= w_nb_a) && (w_mag_c >= w_nb_b);

    always_comb begin
        w_cls = CLS_NONE;
        if (w_survivor) begin
            if (w_mag_c >= r_th_high) begin
                w_cls = CLS_STRONG;
            end else if (w_mag_c > r_th_low) begin
                w_cls = CLS_WEAK;
            end
        end
    end

    generate
        if (OUT_MODE == 1) begin : g_raw
            assign w_dout = w_survivor ? w_mag_c : '0;
        end else begin : g_bin
            always_comb begin
                case (w_cls)
                    CLS_STRONG: w_dout = '1;
                    CLS_WEAK:   w_dout = w_mag_c;
                    default:    w_dout = '0;
                endcase
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_cnt       <= '0;
            r_issue     <= 1'b0;
            r_issue_col <= '0;
            r_th_high   <= '0;
            r_th_low    <= '0;
            valid_out   <= 1'b0;
            dout        <= '0;
            cls         <= CLS_NONE;
            eol_out     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_issue     <= w_issue_nx;
            r_issue_col <= w_issue_col_nx;
            if (w_sof_acc) begin
                r_th_high <= th_high;
                r_th_low  <= th_low;
            end
            if (r_issue && !w_kill) begin
                valid_out <= 1'b1;
                dout      <= w_dout;
                cls       <= w_cls;
                eol_out   <= (r_issue_col == c_last_col);
            end else begin
                valid_out <= 1'b0;
                dout      <= '0;
                cls       <= CLS_NONE;
                eol_out   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nms_hysteresis.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nms_hysteresis
//  Description : Directed bench for nms_hysteresis (IMG_W=5). Two instances:
//                dut0 in binary output mode, dut1 in raw output mode. Expected
//                results are queued when a row is sent and popped by a monitor
//                whenever an instance presents valid_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nms_hysteresis;

    localparam int         c_img_w  = 5;
    localparam int         c_mag_w  = 8;
    localparam int         c_cnt_w  = 3;
    localparam logic [1:0] c_none   = 2'b00;
    localparam logic [1:0] c_weak   = 2'b01;
    localparam logic [1:0] c_strong = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid0 = 1'b0, valid1 = 1'b0, sof = 1'b0;
    logic [9:0]  din1 = '0, din2 = '0, din3 = '0;
    logic [7:0]  th_high = '0, th_low = '0;
    logic        sel = 1'b0;

    logic        ready0, vout0, eol0;
    logic [7:0]  dout0;
    logic [1:0]  cls0;
    logic        ready1, vout1, eol1;
    logic [7:0]  dout1;
    logic [1:0]  cls1;

    always #5 clk = ~clk;

    nms_hysteresis #(.IMG_W(c_img_w), .MAG_W(c_mag_w), .CNT_W(c_cnt_w), .OUT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid0), .ready_out(ready0), .sof(sof),
        .din1(din1), .din2(din2), .din3(din3), .th_high(th_high), .th_low(th_low),
        .valid_out(vout0), .dout(dout0), .cls(cls0), .eol_out(eol0)
    );

    nms_hysteresis #(.IMG_W(c_img_w), .MAG_W(c_mag_w), .CNT_W(c_cnt_w), .OUT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid1), .ready_out(ready1), .sof(sof),
        .din1(din1), .din2(din2), .din3(din3), .th_high(th_high), .th_low(th_low),
        .valid_out(vout1), .dout(dout1), .cls(cls1), .eol_out(eol1)
    );

    typedef struct packed {
        logic       eol;
        logic [1:0] cls;
        logic [7:0] dout;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    logic [9:0] ct[5];
    logic [9:0] cm[5];
    logic [9:0] cb[5];

    // ---------------- scoreboard monitor ----------------
    task automatic check_out(input int which, input exp_t got);
        exp_t e;
        checks++;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL out%0d unexpected output: eol=%0d cls=%0d dout=%0d, none required",
                     which, got.eol, got.cls, got.dout);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL out%0d result: got eol=%0d cls=%0d dout=%0d, required eol=%0d cls=%0d dout=%0d",
                         which, got.eol, got.cls, got.dout, e.eol, e.cls, e.dout);
            end
        end
    endtask

    always @(negedge clk) begin
        if (vout0) check_out(0, {eol0, cls0, dout0});
        if (vout1) check_out(1, {eol1, cls1, dout1});
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic push(input int which, input logic e, input logic [1:0] c, input logic [7:0] d);
        exp_t x;
        x = {e, c, d};
        if (which == 0) q0.push_back(x);
        else            q1.push_back(x);
    endtask

    // Border centres always report none; the last one carries eol.
    task automatic exp_row(input int which,
                           input logic [1:0] c1, input logic [7:0] d1,
                           input logic [1:0] c2, input logic [7:0] d2,
                           input logic [1:0] c3, input logic [7:0] d3);
        push(which, 1'b0, c_none, 8'd0);
        push(which, 1'b0, c1, d1);
        push(which, 1'b0, c2, d2);
        push(which, 1'b0, c3, d3);
        push(which, 1'b1, c_none, 8'd0);
    endtask

    task automatic set_uniform(input logic [7:0] mag, input logic [1:0] dir);
        for (int i = 0; i < 5; i++) begin
            ct[i] = {mag, dir};
            cm[i] = {mag, dir};
            cb[i] = {mag, dir};
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic beat(input logic s, input logic [9:0] t, input logic [9:0] m,
                        input logic [9:0] b, output int waited);
        sof  = s;
        din1 = t;
        din2 = m;
        din3 = b;
        if (sel) valid1 = 1'b1;
        else     valid0 = 1'b1;
        waited = 0;
        while (!(sel ? ready1 : ready0) && waited <= 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited > 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready low for %0d cycles, required at most 1", waited);
        end else begin
            @(posedge clk);
            #1;
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        sof    = 1'b0;
    endtask

    task automatic send_row(input logic s, input int gap, output int w0);
        int w;
        for (int i = 0; i < 5; i++) begin
            if (gap > 0 && i > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            beat((i == 0) ? s : 1'b0, ct[i], cm[i], cb[i], w);
            if (i == 0) w0 = w;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        rst = 1'b1;
        idle(3);
        check("rst_valid_out", int'(vout0), 0);
        check("rst_dout",      int'(dout0), 0);
        check("rst_cls",       int'(cls0),  0);
        check("rst_eol",       int'(eol0),  0);
        check("rst_ready0",    int'(ready0), 1);
        check("rst_ready1",    int'(ready1), 1);
        rst = 1'b0;
        idle(1);

        // Binary mode, thresholds 90/45
        sel = 1'b0;
        th_high = 8'd90;
        th_low  = 8'd45;

        // Flat horizontal-gradient row: interior strong, borders none
        set_uniform(8'd100, 2'd2);
        exp_row(0, c_strong, 8'd255, c_strong, 8'd255, c_strong, 8'd255);
        send_row(1'b1, 0, w);
        check("first_col0_wait", w, 0);

        // Vertical dir: top neighbour larger suppresses the centre
        set_uniform(8'd0, 2'd0);
        cm[2] = {8'd60, 2'd0};
        ct[2] = {8'd70, 2'd0};
        exp_row(0, c_none, 8'd0, c_none, 8'd0, c_none, 8'd0);
        send_row(1'b0, 0, w);
        check("flush_ready_low_cycles", w, 1);

        // Tie with top neighbour survives, 45 < 60 < 90 -> weak
        ct[2] = {8'd60, 2'd0};
        exp_row(0, c_none, 8'd0, c_weak, 8'd60, c_none, 8'd0);
        send_row(1'b0, 0, w);

        // Diagonal: top-right 120 beats centre 100 along dir 1
        set_uniform(8'd0, 2'd0);
        cm[2] = {8'd100, 2'd1};
        ct[3] = {8'd120, 2'd0};
        exp_row(0, c_none, 8'd0, c_none, 8'd0, c_none, 8'd0);
        send_row(1'b0, 0, w);

        // Same window along dir 3 survives; beats spaced by idle cycles
        cm[2] = {8'd100, 2'd3};
        exp_row(0, c_none, 8'd0, c_strong, 8'd255, c_none, 8'd0);
        send_row(1'b0, 2, w);

        // Partial row cut short by sof; new thresholds 50/20 -> mag 40 weak
        set_uniform(8'd100, 2'd2);
        beat(1'b0, ct[0], cm[0], cb[0], w);
        beat(1'b0, ct[1], cm[1], cb[1], w);
        th_high = 8'd50;
        th_low  = 8'd20;
        set_uniform(8'd40, 2'd2);
        exp_row(0, c_weak, 8'd40, c_weak, 8'd40, c_weak, 8'd40);
        send_row(1'b1, 0, w);
        idle(5);

        // Raw mode instance
        sel = 1'b1;
        th_high = 8'd90;
        th_low  = 8'd45;
        set_uniform(8'd30, 2'd2);
        exp_row(1, c_none, 8'd30, c_none, 8'd30, c_none, 8'd30);
        send_row(1'b1, 0, w);
        set_uniform(8'd100, 2'd2);
        exp_row(1, c_strong, 8'd100, c_strong, 8'd100, c_strong, 8'd100);
        send_row(1'b0, 0, w);
        idle(5);

        // Reset mid-row: centre 0 emerges, the in-flight centre 1 is dropped
        push(1, 1'b0, c_none, 8'd0);
        beat(1'b0, ct[0], cm[0], cb[0], w);
        beat(1'b0, ct[1], cm[1], cb[1], w);
        beat(1'b0, ct[2], cm[2], cb[2], w);
        rst = 1'b1;
        idle(1);
        check("midrow_rst_valid_out", int'(vout1), 0);
        check("midrow_rst_dout",      int'(dout1), 0);
        check("midrow_rst_cls",       int'(cls1),  0);
        check("midrow_rst_ready",     int'(ready1), 1);
        rst = 1'b0;
        idle(1);

        exp_row(1, c_strong, 8'd100, c_strong, 8'd100, c_strong, 8'd100);
        send_row(1'b1, 0, w);
        idle(6);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
